// File: rtl/alu_pkg.sv
// Shared opcode map, FSM states and flag bundle for the sequential ALU.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_DIV = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_OR  = 4'd5;
    localparam logic [3:0] OP_XOR = 4'd6;
    localparam logic [3:0] OP_NOT = 4'd7;
    localparam logic [3:0] OP_SHL = 4'd8;
    localparam logic [3:0] OP_SHR = 4'd9;
    localparam logic [3:0] OP_REM = 4'd10;

    typedef enum logic {
        IDLE = 1'b0,
        DIV  = 1'b1
    } state_e;

    // err causes:
    //   illegal opcode   -> y = 0
    //   DIV by zero      -> y = all ones, overflow = 0
    //   REM by zero      -> y = a
    typedef struct packed {
        logic zero;
        logic negative;
        logic carry;
        logic overflow;
        logic err;
    } flags_t;

endpackage

// File: rtl/alu_seq_if.sv
// Operand/opcode request and result/flag response channels of alu_seq.
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       opcode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             zero;
    logic             negative;
    logic             carry;
    logic             overflow;
    logic             err;

    modport master (
        output in_valid, opcode, a, b, out_ready,
        input  in_ready, out_valid, y, zero, negative, carry, overflow, err
    );

    modport slave (
        input  in_valid, opcode, a, b, out_ready,
        output in_ready, out_valid, y, zero, negative, carry, overflow, err
    );
endinterface

// File: rtl/alu_div_iter.sv
// Iterative restoring unsigned divider: one quotient bit per clock, the first
// bit is produced on the start edge so done rises WIDTH cycles after start.
module alu_div_iter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);
    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;

    logic [WIDTH-1:0] src_rem, src_quo, src_dvs;
    logic [WIDTH:0]   shifted;
    logic             fits;
    logic [WIDTH-1:0] step_rem, step_quo;

    always_comb begin
        src_rem  = start ? '0 : rem_q;
        src_quo  = start ? dividend : quo_q;
        src_dvs  = start ? divisor : dvs_q;
        shifted  = {src_rem, src_quo[WIDTH-1]};
        fits     = shifted >= {1'b0, src_dvs};
        // When the trial subtraction fits, its result is below the divisor,
        // so the low WIDTH bits carry the whole partial remainder.
        step_rem = fits ? (shifted[WIDTH-1:0] - src_dvs) : shifted[WIDTH-1:0];
        step_quo = {src_quo[WIDTH-2:0], fits};
    end

    always_comb begin
        rem_d  = rem_q;
        quo_d  = quo_q;
        dvs_d  = dvs_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (start) begin
            rem_d  = step_rem;
            quo_d  = step_quo;
            dvs_d  = divisor;
            cnt_d  = CW'(WIDTH - 1);
            busy_d = 1'b1;
        end else if (busy_q) begin
            if (cnt_q != '0) begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q - 1'b1;
            end else begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign done      = busy_q && (cnt_q == '0);
    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/alu_seq.sv
// Handshaked WIDTH-bit ALU with registered single-entry output and multi-cycle DIV.
// Define ALU_SEQ_REMAINDER_EN to enable opcode 4'b1010 (REM) on the shared divider.
//
//   state | meaning
//   IDLE  | accepting ops whenever the output slot is free or draining
//   DIV   | divider iterating; input stalled until the result is loaded
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input logic      clk,
    input logic      rst,
    alu_seq_if.slave bus
);
    localparam logic [WIDTH-1:0] SH_LIM = WIDTH'(WIDTH);

    state_e           state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] y_q, y_d;
    flags_t           flags_q, flags_d;
    logic             is_rem_q, is_rem_d;

    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   diff;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   op_y;
    logic               op_c, op_v, op_e, op_iter, op_rem;

    logic             accept;
    logic             div_start, div_done;
    logic [WIDTH-1:0] div_quo, div_rem, div_res;

    assign bus.in_ready = (state_q == IDLE) && (!out_valid_q || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;

    alu_div_iter #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .dividend  (bus.a),
        .divisor   (bus.b),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    always_comb begin
        sum     = {1'b0, bus.a} + {1'b0, bus.b};
        diff    = bus.a - bus.b;
        prod    = {{WIDTH{1'b0}}, bus.a} * {{WIDTH{1'b0}}, bus.b};
        op_y    = '0;
        op_c    = 1'b0;
        op_v    = 1'b0;
        op_e    = 1'b0;
        op_iter = 1'b0;
        op_rem  = 1'b0;
        case (bus.opcode)
            OP_ADD: begin
                op_y = sum[WIDTH-1:0];
                op_c = sum[WIDTH];
                op_v = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (op_y[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB: begin
                op_y = diff;
                op_c = bus.a < bus.b;
                op_v = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (op_y[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_MUL: begin
                op_y = prod[WIDTH-1:0];
                op_v = |prod[2*WIDTH-1:WIDTH];
            end
            OP_DIV: begin
                if (bus.b == '0) begin
                    op_y = '1;
                    op_e = 1'b1;
                end else begin
                    op_iter = 1'b1;
                end
            end
            OP_AND: op_y = bus.a & bus.b;
            OP_OR:  op_y = bus.a | bus.b;
            OP_XOR: op_y = bus.a ^ bus.b;
            OP_NOT: op_y = ~bus.a;
            OP_SHL: op_y = (bus.b >= SH_LIM) ? '0 : (bus.a << bus.b);
            OP_SHR: op_y = (bus.b >= SH_LIM) ? '0 : (bus.a >> bus.b);
`ifdef ALU_SEQ_REMAINDER_EN
            OP_REM: begin
                if (bus.b == '0) begin
                    op_y = bus.a;
                    op_e = 1'b1;
                end else begin
                    op_iter = 1'b1;
                    op_rem  = 1'b1;
                end
            end
`endif
            default: op_e = 1'b1;
        endcase
    end

    assign div_res = is_rem_q ? div_rem : div_quo;

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        y_d         = y_q;
        flags_d     = flags_q;
        is_rem_d    = is_rem_q;
        div_start   = 1'b0;
        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (op_iter) begin
                        state_d   = DIV;
                        div_start = 1'b1;
                        is_rem_d  = op_rem;
                    end else begin
                        out_valid_d      = 1'b1;
                        y_d              = op_y;
                        flags_d.zero     = (op_y == '0);
                        flags_d.negative = op_y[WIDTH-1];
                        flags_d.carry    = op_c;
                        flags_d.overflow = op_v;
                        flags_d.err      = op_e;
                    end
                end
            end
            DIV: begin
                if (div_done) begin
                    state_d          = IDLE;
                    out_valid_d      = 1'b1;
                    y_d              = div_res;
                    flags_d.zero     = (div_res == '0);
                    flags_d.negative = div_res[WIDTH-1];
                    flags_d.carry    = 1'b0;
                    flags_d.overflow = 1'b0;
                    flags_d.err      = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            y_q         <= '0;
            flags_q     <= '0;
            is_rem_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            y_q         <= y_d;
            flags_q     <= flags_d;
            is_rem_q    <= is_rem_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.y         = y_q;
    assign bus.zero      = flags_q.zero;
    assign bus.negative  = flags_q.negative;
    assign bus.carry     = flags_q.carry;
    assign bus.overflow  = flags_q.overflow;
    assign bus.err       = flags_q.err;

endmodule
